// File: rtl/multi_pi_controller.sv
// Time-multiplexed incremental PI speed controller for N_CH motor channels.
// One shared multiplier; each channel takes FETCH/MUL_P/MUL_I/UPDATE, then all outputs commit together.
module multi_pi_controller #(
  parameter int N_CH    = 4,
  parameter int WIDTH   = 16,
  parameter int FRAC    = 8,
  parameter int GAIN_W  = 16,
  parameter int PWM_MAX = 200,
  parameter int PWM_MIN = 5
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  input  logic                    sample_tick,
  input  logic [N_CH*WIDTH-1:0]   error_in,
  input  logic [N_CH-1:0]         ch_en,
  input  logic [GAIN_W-1:0]       kp,
  input  logic [GAIN_W-1:0]       ki,
  input  logic                    clr_ovr,
  output logic [N_CH*8-1:0]       pwm_out,
  output logic [N_CH-1:0]         dir_out,
  output logic [N_CH-1:0]         sat_out,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  localparam int DW = WIDTH + 1;
  localparam int PW = GAIN_W + 1 + DW;
  localparam int SW = WIDTH + GAIN_W + 3;
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic signed [SW-1:0] U_MAX = SW'(PWM_MAX * (2 ** FRAC));

  typedef enum logic [2:0] {IDLE, FETCH, MUL_P, MUL_I, UPDATE, COMMIT} state_t;

  state_t                   state_q;
  logic [CW-1:0]            ch_q;
  logic signed [WIDTH-1:0]  err_snap_q [N_CH];
  logic [N_CH-1:0]          en_snap_q;
  logic [GAIN_W-1:0]        kp_q;
  logic [GAIN_W-1:0]        ki_q;
  logic signed [WIDTH-1:0]  ek_q;
  logic signed [DW-1:0]     d_q;
  logic signed [SW-1:0]     p_q;
  logic signed [SW-1:0]     i_q;
  logic signed [SW-1:0]     u_q [N_CH];
  logic signed [WIDTH-1:0]  eprev_q [N_CH];
  logic [N_CH*8-1:0]        sh_pwm_q;
  logic [N_CH-1:0]          sh_dir_q;
  logic [N_CH-1:0]          sh_sat_q;
  logic [N_CH*8-1:0]        pwm_q;
  logic [N_CH-1:0]          dir_q;
  logic [N_CH-1:0]          sat_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     ovr_q;

  logic signed [WIDTH-1:0]  fetch_e;
  logic signed [DW-1:0]     fetch_d;
  logic [GAIN_W-1:0]        mul_a;
  logic signed [DW-1:0]     mul_b;
  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     prod_sh;
  logic signed [SW-1:0]     mul_res;
  logic signed [SW-1:0]     sum;
  logic signed [SW-1:0]     u_new;
  logic                     clamp;
  logic [SW-1:0]            mag;
  logic [SW-1:0]            int_part;
  logic [7:0]               pwm_new;
  logic                     dir_new;
  logic                     ch_on;
  logic                     last_ch;
  logic [N_CH*8-1:0]        sh_pwm_d;
  logic [N_CH-1:0]          sh_dir_d;
  logic [N_CH-1:0]          sh_sat_d;

  // Shared datapath: the multiplier serves kp*d in MUL_P and ki*e in MUL_I.
  always_comb begin
    fetch_e  = err_snap_q[ch_q];
    fetch_d  = DW'(fetch_e) - DW'(eprev_q[ch_q]);
    mul_a    = (state_q == MUL_P) ? kp_q : ki_q;
    mul_b    = (state_q == MUL_P) ? d_q : DW'(ek_q);
    prod     = PW'($signed({1'b0, mul_a})) * PW'(mul_b);
    prod_sh  = prod >>> FRAC;
    mul_res  = SW'(prod_sh);
    ch_on    = en_snap_q[ch_q];
    last_ch  = (ch_q == CW'(N_CH - 1));

    sum   = u_q[ch_q] + p_q + i_q;
    clamp = 1'b0;
    u_new = sum;
    if (sum > U_MAX) begin
      u_new = U_MAX;
      clamp = 1'b1;
    end else if (sum < -U_MAX) begin
      u_new = -U_MAX;
      clamp = 1'b1;
    end

    mag      = u_new[SW-1] ? -u_new : u_new;
    int_part = mag >> FRAC;
    pwm_new  = '0;
    dir_new  = 1'b0;
    if (int_part > SW'(PWM_MIN)) begin
      pwm_new = (int_part > SW'(255)) ? 8'hFF : int_part[7:0];
      dir_new = u_new[SW-1];
    end

    sh_pwm_d = sh_pwm_q;
    sh_dir_d = sh_dir_q;
    sh_sat_d = sh_sat_q;
    sh_pwm_d[int'(ch_q)*8 +: 8] = ch_on ? pwm_new : 8'h00;
    sh_dir_d[ch_q]              = ch_on & dir_new;
    sh_sat_d[ch_q]              = ch_on & clamp;
  end

  // Sweep sequencer; outputs are copied from the shadow set only on the edge into COMMIT.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      en_snap_q <= '0;
      kp_q      <= '0;
      ki_q      <= '0;
      ek_q      <= '0;
      d_q       <= '0;
      p_q       <= '0;
      i_q       <= '0;
      sh_pwm_q  <= '0;
      sh_dir_q  <= '0;
      sh_sat_q  <= '0;
      pwm_q     <= '0;
      dir_q     <= '0;
      sat_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        u_q[c]        <= '0;
        eprev_q[c]    <= '0;
        err_snap_q[c] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (sample_tick && (state_q != IDLE))
        ovr_q <= 1'b1;
      else if (clr_ovr)
        ovr_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (sample_tick) begin
            for (int c = 0; c < N_CH; c++)
              err_snap_q[c] <= error_in[c*WIDTH +: WIDTH];
            en_snap_q <= ch_en;
            kp_q      <= kp;
            ki_q      <= ki;
            ch_q      <= '0;
            busy_q    <= 1'b1;
            state_q   <= FETCH;
          end
        end
        FETCH: begin
          ek_q    <= fetch_e;
          d_q     <= fetch_d;
          state_q <= MUL_P;
        end
        MUL_P: begin
          p_q     <= mul_res;
          state_q <= MUL_I;
        end
        MUL_I: begin
          i_q     <= mul_res;
          state_q <= UPDATE;
        end
        UPDATE: begin
          u_q[ch_q]     <= ch_on ? u_new : '0;
          eprev_q[ch_q] <= ch_on ? ek_q : '0;
          sh_pwm_q      <= sh_pwm_d;
          sh_dir_q      <= sh_dir_d;
          sh_sat_q      <= sh_sat_d;
          if (last_ch) begin
            pwm_q   <= sh_pwm_d;
            dir_q   <= sh_dir_d;
            sat_q   <= sh_sat_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= COMMIT;
          end else begin
            ch_q    <= ch_q + CW'(1);
            state_q <= FETCH;
          end
        end
        COMMIT: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pwm_out = pwm_q;
  assign dir_out = dir_q;
  assign sat_out = sat_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_multi_pi_controller.sv
// Directed bench for multi_pi_controller: a reference PI model fills a scoreboard on each
// accepted tick, and each done pulse pops and compares one coherent output set.
module tb_multi_pi_controller;

  localparam int N_CH = 4;

  typedef struct packed {
    logic [31:0] pwm;
    logic [3:0]  dir;
    logic [3:0]  sat;
  } exp_t;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N;
  logic        sample_tick;
  logic [63:0] error_in;
  logic [3:0]  ch_en;
  logic [15:0] kp;
  logic [15:0] ki;
  logic        clr_ovr;
  logic [31:0] pwm_out;
  logic [3:0]  dir_out;
  logic [3:0]  sat_out;
  logic        busy;
  logic        done;
  logic        overrun;

  int     checkCount = 0;
  int     errorCount = 0;
  exp_t   sbq[$];
  longint uModel[N_CH];
  longint epModel[N_CH];

  multi_pi_controller dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .sample_tick (sample_tick),
    .error_in    (error_in),
    .ch_en       (ch_en),
    .kp          (kp),
    .ki          (ki),
    .clr_ovr     (clr_ovr),
    .pwm_out     (pwm_out),
    .dir_out     (dir_out),
    .sat_out     (sat_out),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checkCount++;
    assert (obs === expv) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drives one tick (at a negedge) and pushes the reference result for that sweep.
  task automatic applyStimulus(input logic signed [15:0] e0, e1, e2, e3,
                               input logic [3:0] en, input logic [15:0] kpIn, kiIn);
    exp_t x;
    logic signed [15:0] ea[N_CH];
    longint d, p, i, s, lim, mag, m;
    ea[0] = e0; ea[1] = e1; ea[2] = e2; ea[3] = e3;
    error_in    = {e3, e2, e1, e0};
    ch_en       = en;
    kp          = kpIn;
    ki          = kiIn;
    sample_tick = 1'b1;
    x   = '0;
    lim = 200 * 256;
    for (int c = 0; c < N_CH; c++) begin
      if (!en[c]) begin
        uModel[c]  = 0;
        epModel[c] = 0;
      end else begin
        d = longint'(ea[c]) - epModel[c];
        p = (longint'(kpIn) * d) >>> 8;
        i = (longint'(kiIn) * longint'(ea[c])) >>> 8;
        s = uModel[c] + p + i;
        x.sat[c] = (s > lim) || (s < -lim);
        if (s > lim) s = lim;
        if (s < -lim) s = -lim;
        uModel[c]  = s;
        epModel[c] = longint'(ea[c]);
        mag = (s < 0) ? -s : s;
        m   = mag >>> 8;
        if (m > 5) begin
          x.pwm[c*8 +: 8] = m[7:0];
          x.dir[c]        = (s < 0);
        end
      end
    end
    sbq.push_back(x);
    @(negedge CLOCK_50);
    sample_tick = 1'b0;
  endtask

  // Bounded wait for done; optionally injects a tick mid-sweep or in the done cycle.
  task automatic waitDone(input string tag, input int tickAt, input bit clrWithTick,
                          input bit tickAtDone);
    int          cyc;
    bit          stable;
    logic [31:0] prevPwm;
    exp_t        x;
    cyc     = 1;
    stable  = 1'b1;
    prevPwm = pwm_out;
    checkOutput({tag, "_busy_start"}, busy, 1);
    while (done !== 1'b1 && cyc < 60) begin
      if (cyc == tickAt) begin
        sample_tick = 1'b1;
        clr_ovr     = clrWithTick;
      end
      @(negedge CLOCK_50);
      sample_tick = 1'b0;
      clr_ovr     = 1'b0;
      cyc++;
      if (done !== 1'b1 && pwm_out !== prevPwm) stable = 1'b0;
    end
    checkOutput({tag, "_latency"}, cyc, 17);
    checkOutput({tag, "_pwm_stable"}, stable, 1);
    checkOutput({tag, "_busy_at_done"}, busy, 0);
    checkOutput({tag, "_sb_nonempty"}, sbq.size() > 0, 1);
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      checkOutput({tag, "_pwm"}, pwm_out, x.pwm);
      checkOutput({tag, "_dir"}, dir_out, x.dir);
      checkOutput({tag, "_sat"}, sat_out, x.sat);
    end
    if (tickAtDone) sample_tick = 1'b1;
    @(negedge CLOCK_50);
    sample_tick = 1'b0;
    checkOutput({tag, "_done_one_cycle"}, done, 0);
    if (tickAtDone) begin
      checkOutput({tag, "_commit_tick_ignored"}, busy, 0);
      checkOutput({tag, "_commit_tick_overrun"}, overrun, 1);
    end
  endtask

  task automatic checkNoDone(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(negedge CLOCK_50);
      if (done === 1'b1) seen++;
    end
    checkOutput(tag, seen, 0);
  endtask

  task automatic clearOverrun(input string tag);
    clr_ovr = 1'b1;
    @(negedge CLOCK_50);
    clr_ovr = 1'b0;
    checkOutput(tag, overrun, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    RESET_N     = 1'b0;
    sample_tick = 1'b0;
    error_in    = '0;
    ch_en       = '0;
    kp          = '0;
    ki          = '0;
    clr_ovr     = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      uModel[c]  = 0;
      epModel[c] = 0;
    end
    repeat (3) @(negedge CLOCK_50);
    checkOutput("rst_outputs", {pwm_out, dir_out, sat_out}, 0);
    checkOutput("rst_flags", {busy, done, overrun}, 0);
    RESET_N = 1'b1;
    @(negedge CLOCK_50);
    checkOutput("post_rst_flags", {busy, done, overrun}, 0);

    $display("[TB] step response");
    applyStimulus(16'sh0A00, 16'shF600, 16'sh0500, 16'sh0000, 4'hF, 16'h0100, 16'h0080);
    waitDone("step1", 0, 0, 0);
    checkOutput("step1_pwm0", pwm_out[7:0], 15);
    checkOutput("step1_dir0", dir_out[0], 0);
    checkOutput("step1_neg_pwm1", pwm_out[15:8], 15);
    checkOutput("step1_neg_dir1", dir_out[1], 1);

    applyStimulus(16'sh0A00, 16'shF600, 16'sh0500, 16'sh0000, 4'hF, 16'h0100, 16'h0080);
    error_in = 64'hDEAD_BEEF_1234_5678;
    kp       = 16'hFFFF;
    ki       = 16'hFFFF;
    ch_en    = 4'h0;
    waitDone("step2", 0, 0, 0);
    checkOutput("step2_pwm0", pwm_out[7:0], 20);

    $display("[TB] saturation and anti-windup");
    applyStimulus(16'sh7F00, 16'shF600, 16'sh0500, 16'sh0000, 4'hF, 16'h0100, 16'h0080);
    waitDone("sat", 0, 0, 0);
    checkOutput("sat_pwm0", pwm_out[7:0], 200);
    checkOutput("sat_flag0", sat_out[0], 1);
    applyStimulus(16'shFF00, 16'shF600, 16'sh0500, 16'sh0000, 4'hF, 16'h0100, 16'h0080);
    waitDone("unwind", 0, 0, 0);
    checkOutput("unwind_pwm0", pwm_out[7:0], 71);
    checkOutput("unwind_sat0", sat_out[0], 0);

    $display("[TB] deadband");
    applyStimulus(16'sh0000, 16'sh0000, 16'sh0500, 16'sh0C00, 4'hF, 16'h0040, 16'h0000);
    waitDone("deadband", 0, 0, 0);
    checkOutput("deadband_pwm3", pwm_out[31:24], 0);
    checkOutput("deadband_dir3", dir_out[3], 0);

    $display("[TB] disable and re-enable");
    applyStimulus(16'sh0100, 16'sh0200, 16'sh3000, 16'sh0C00, 4'b1011, 16'h0100, 16'h0080);
    waitDone("disable", 0, 0, 0);
    checkOutput("disable_pwm2", pwm_out[23:16], 0);
    applyStimulus(16'sh0100, 16'sh0200, 16'sh0A00, 16'sh0C00, 4'hF, 16'h0100, 16'h0000);
    waitDone("reenable", 0, 0, 0);
    checkOutput("reenable_pwm2", pwm_out[23:16], 10);

    $display("[TB] overrun");
    applyStimulus(16'sh0200, 16'sh0300, 16'sh0100, 16'sh0000, 4'hF, 16'h0080, 16'h0040);
    waitDone("ovrA", 5, 0, 0);
    checkOutput("ovrA_flag", overrun, 1);
    checkNoDone("ovrA_single_done", 20);
    clearOverrun("ovrA_clear");
    applyStimulus(16'sh0200, 16'sh0300, 16'sh0100, 16'sh0000, 4'hF, 16'h0080, 16'h0040);
    waitDone("ovrB", 3, 1, 0);
    checkOutput("ovrB_set_wins", overrun, 1);
    clearOverrun("ovrB_clear");
    applyStimulus(16'sh0400, 16'sh0300, 16'sh0100, 16'sh0000, 4'hF, 16'h0080, 16'h0040);
    waitDone("ovrC", 0, 0, 1);
    clearOverrun("ovrC_clear");

    $display("[TB] reset mid-sweep");
    applyStimulus(16'sh7000, 16'sh7000, 16'sh7000, 16'sh7000, 4'hF, 16'h0100, 16'h0080);
    repeat (7) @(negedge CLOCK_50);
    RESET_N = 1'b0;
    #1;
    checkOutput("midrst_outputs", {pwm_out, dir_out, sat_out}, 0);
    checkOutput("midrst_flags", {busy, done, overrun}, 0);
    void'(sbq.pop_back());
    for (int c = 0; c < N_CH; c++) begin
      uModel[c]  = 0;
      epModel[c] = 0;
    end
    repeat (2) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    checkNoDone("midrst_no_done", 20);
    applyStimulus(16'sh0A00, 16'sh0000, 16'sh0000, 16'sh0000, 4'hF, 16'h0100, 16'h0080);
    waitDone("fresh", 0, 0, 0);
    checkOutput("fresh_pwm0", pwm_out[7:0], 15);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
